// File: rtl/ctrl_pipe_chain_if.sv
// Bundle of the decode-side inputs and stage outputs of ctrl_pipe_chain.
// master = decoder / hazard-unit side, slave = the pipeline itself.
interface ctrl_pipe_chain_if #(
   parameter int W      = 15,
   parameter int STAGES = 3
);
   logic [W-1:0]          ctrl_in;
   logic                  valid_in;
   logic                  mc_in;
   logic [STAGES-1:0]     flush;
   logic                  stall_ext;
   logic [STAGES*W-1:0]   ctrl_out;
   logic [STAGES-1:0]     valid_out;
   logic                  stall_up;
   logic                  mc_busy;
   logic                  mc_done;
   logic [31:0]           perf_bubbles;
   logic [31:0]           perf_mc_cycles;

   modport master (
      output ctrl_in, valid_in, mc_in, flush, stall_ext,
      input  ctrl_out, valid_out, stall_up, mc_busy, mc_done,
             perf_bubbles, perf_mc_cycles
   );

   modport slave (
      input  ctrl_in, valid_in, mc_in, flush, stall_ext,
      output ctrl_out, valid_out, stall_up, mc_busy, mc_done,
             perf_bubbles, perf_mc_cycles
   );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode through STAGES stages (stage 0 = E).
// Adds per-stage flush, global hold (stall_ext) and a multi-cycle-op
// sequencer in E that holds E, bubbles M and back-pressures fetch/decode.
// Optional macro CTRL_PIPE_PERF_EN enables the bubble / stall-cycle counters;
// without it perf_bubbles and perf_mc_cycles read as zero.
module ctrl_pipe_chain #(
   parameter int W         = 15,
   parameter int STAGES    = 3,
   parameter int MC_CYCLES = 32,
   parameter int CNT_W     = $clog2(MC_CYCLES) + 1
) (
   input  logic             clk,
   input  logic             rst,
   ctrl_pipe_chain_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CHECK, BUSY, DONE} seqState_t;

   seqState_t                     state;
   logic [CNT_W-1:0]              cnt;
   logic                          mcDoneQ;
   logic [STAGES-1:0][W-1:0]      ctrlQ;
   logic [STAGES-1:0]             vldQ;
   logic                          mcQ;
   logic                          mcStart;
   logic                          mcBusy;
   logic                          hold0;

   // A multi-cycle op sitting in E is picked up in the same cycle it is seen,
   // so E holds immediately instead of leaking one cycle downstream.
   assign mcStart = (state == IDLE) & vldQ[0] & mcQ & ~bus.flush[0];
   assign mcBusy  = mcStart | (state == BUSY) | (state == CHECK);
   assign hold0   = bus.stall_ext | mcBusy;

   // Stage registers: flush beats hold; E holds during an mc op while M takes bubbles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrlQ <= '0;
         vldQ  <= '0;
         mcQ   <= 1'b0;
      end else begin
         if (bus.flush[0]) begin
            ctrlQ[0] <= '0;
            vldQ[0]  <= 1'b0;
            mcQ      <= 1'b0;
         end else if (!hold0) begin
            ctrlQ[0] <= bus.ctrl_in;
            vldQ[0]  <= bus.valid_in;
            mcQ      <= bus.mc_in;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (bus.flush[k]) begin
               ctrlQ[k] <= '0;
               vldQ[k]  <= 1'b0;
            end else if (!bus.stall_ext) begin
               if (k == 1 && mcBusy) begin
                  ctrlQ[k] <= '0;
                  vldQ[k]  <= 1'b0;
               end else begin
                  ctrlQ[k] <= ctrlQ[k-1];
                  vldQ[k]  <= vldQ[k-1];
               end
            end
         end
      end
   end

   // Multi-cycle sequencer; the busy count keeps running under stall_ext
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         mcDoneQ <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mcStart) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(MC_CYCLES - 1);
               end
            end
            BUSY: begin
               if (bus.flush[0]) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  state   <= DONE;
                  mcDoneQ <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (bus.flush[0] || !bus.stall_ext) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  mcDoneQ <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               mcDoneQ <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ctrl_out  = ctrlQ;
   assign bus.valid_out = vldQ;
   assign bus.stall_up  = hold0;
   assign bus.mc_busy   = mcBusy;
   assign bus.mc_done   = mcDoneQ;

`ifdef CTRL_PIPE_PERF_EN
   logic [31:0] perfBubbles;
   logic [31:0] perfMcCycles;

   // Count M bubbles actually inserted and every cycle fetch/decode is held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perfBubbles  <= '0;
         perfMcCycles <= '0;
      end else begin
         if (mcBusy && !bus.stall_ext && !bus.flush[1])
            perfBubbles <= perfBubbles + 32'd1;
         if (hold0)
            perfMcCycles <= perfMcCycles + 32'd1;
      end
   end

   assign bus.perf_bubbles   = perfBubbles;
   assign bus.perf_mc_cycles = perfMcCycles;
`else
   assign bus.perf_bubbles   = 32'h0;
   assign bus.perf_mc_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_ctrl_pipe_chain;
   localparam int W         = 15;
   localparam int STAGES    = 3;
   localparam int MC_CYCLES = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_pipe_chain_if #(.W(W), .STAGES(STAGES)) busIf ();

   ctrl_pipe_chain #(.W(W), .STAGES(STAGES), .MC_CYCLES(MC_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   int checks   = 0;
   int failures = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: stage contents plus "busy cycles still owed" and a done flag
   logic [W-1:0]      mCtrl [STAGES];
   logic              mVld  [STAGES];
   logic              mMc0;
   int                busyLeft;
   bit                doneFlag;
   int unsigned       mBub, mMcCyc;
   logic [W-1:0]      iCtrl;
   logic              iVld, iMc, iStall;
   logic [STAGES-1:0] iFlush;
   int                nStall, nDone;

   function automatic void modelReset();
      for (int k = 0; k < STAGES; k++) begin
         mCtrl[k] = '0;
         mVld[k]  = 1'b0;
      end
      mMc0 = 1'b0; busyLeft = 0; doneFlag = 1'b0; mBub = 0; mMcCyc = 0;
   endfunction

   function automatic bit modelDetect();
      return !doneFlag && busyLeft == 0 && mVld[0] && mMc0 && !iFlush[0];
   endfunction

   function automatic bit modelBusy();
      return modelDetect() || busyLeft > 0;
   endfunction

   function automatic void modelAdvance();
      bit busy, detect;
      busy   = modelBusy();
      detect = modelDetect();
      if (busy && !iStall && !iFlush[1]) mBub++;
      if (busy || iStall) mMcCyc++;
      for (int k = STAGES - 1; k >= 1; k--) begin
         if (iFlush[k]) begin mCtrl[k] = '0; mVld[k] = 1'b0; end
         else if (iStall) begin end
         else if (k == 1 && busy) begin mCtrl[k] = '0; mVld[k] = 1'b0; end
         else begin mCtrl[k] = mCtrl[k-1]; mVld[k] = mVld[k-1]; end
      end
      if (iFlush[0]) begin mCtrl[0] = '0; mVld[0] = 1'b0; mMc0 = 1'b0; end
      else if (!(iStall || busy)) begin mCtrl[0] = iCtrl; mVld[0] = iVld; mMc0 = iMc; end
      if (iFlush[0]) begin busyLeft = 0; doneFlag = 1'b0; end
      else if (detect) busyLeft = MC_CYCLES;
      else if (busyLeft > 0) begin
         busyLeft--;
         if (busyLeft == 0) doneFlag = 1'b1;
      end else if (doneFlag && !iStall) doneFlag = 1'b0;
   endfunction

   task automatic checkAll(input string tag);
      logic [STAGES*W-1:0] eCtrl;
      logic [STAGES-1:0]   eVld;
      for (int k = 0; k < STAGES; k++) begin
         eCtrl[k*W +: W] = mCtrl[k];
         eVld[k]         = mVld[k];
      end
      checkVal({tag, ".ctrl"},   64'(busIf.ctrl_out),  64'(eCtrl));
      checkVal({tag, ".valid"},  64'(busIf.valid_out), 64'(eVld));
      checkVal({tag, ".stall"},  64'(busIf.stall_up),  64'(modelBusy() || iStall));
      checkVal({tag, ".busy"},   64'(busIf.mc_busy),   64'(modelBusy()));
      checkVal({tag, ".done"},   64'(busIf.mc_done),   64'(doneFlag));
`ifdef CTRL_PIPE_PERF_EN
      checkVal({tag, ".pbub"},   64'(busIf.perf_bubbles),   64'(mBub));
      checkVal({tag, ".pmc"},    64'(busIf.perf_mc_cycles), 64'(mMcCyc));
`else
      checkVal({tag, ".pbub"},   64'(busIf.perf_bubbles),   64'h0);
      checkVal({tag, ".pmc"},    64'(busIf.perf_mc_cycles), 64'h0);
`endif
   endtask

   // Called at posedge+1: drive one cycle of inputs, check mid-cycle, step model
   task automatic cycle(input logic [W-1:0] c, input logic v, input logic m,
                        input logic [STAGES-1:0] f, input logic s, input string tag);
      iCtrl = c; iVld = v; iMc = m; iFlush = f; iStall = s;
      busIf.ctrl_in = c; busIf.valid_in = v; busIf.mc_in = m;
      busIf.flush = f; busIf.stall_ext = s;
      #4;
      checkAll(tag);
      nStall += int'(busIf.stall_up);
      nDone  += int'(busIf.mc_done);
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1);
   end

   initial begin
      logic [31:0]       pb0, pm0;
      logic [2*W-1:0]    low0;
      logic [1:0]        lowV0;
      nStall = 0; nDone = 0;
      iCtrl = '0; iVld = 0; iMc = 0; iFlush = '0; iStall = 0;
      busIf.ctrl_in = '0; busIf.valid_in = 0; busIf.mc_in = 0;
      busIf.flush = '0; busIf.stall_ext = 0;
      rst = 1'b0;
      modelReset();
      #12;
      checkAll("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // Plain streaming: one cycle per stage
      cycle(15'h1234, 1, 0, '0, 0, "seq0");
      cycle(15'h0567, 1, 0, '0, 0, "seq1");
      cycle(15'h7ABC, 1, 0, '0, 0, "seq2");
      checkVal("seqStages", 64'(busIf.ctrl_out), 64'({15'h1234, 15'h0567, 15'h7ABC}));
      checkVal("seqValid", 64'(busIf.valid_out), 64'h7);
      cycle(15'h0000, 0, 0, '0, 0, "seq3");

      // Multi-cycle op: 5 stall cycles, one done cycle, 5 bubbles
      pb0 = busIf.perf_bubbles; pm0 = busIf.perf_mc_cycles;
      nStall = 0; nDone = 0;
      cycle(15'h0042, 1, 1, '0, 0, "mcIn");
      for (int i = 0; i < 10; i++) cycle(15'h0100, 1, 0, '0, 0, "mcRun");
      checkVal("mcStallCycles", 64'(nStall), 64'd5);
      checkVal("mcDoneCycles", 64'(nDone), 64'd1);
`ifdef CTRL_PIPE_PERF_EN
      checkVal("mcPerfBub", 64'(busIf.perf_bubbles - pb0), 64'd5);
      checkVal("mcPerfCyc", 64'(busIf.perf_mc_cycles - pm0), 64'd5);
`endif

      // stall_ext held 3 cycles while done: done stays up 4 cycles, E holds op
      nDone = 0;
      cycle(15'h0042, 1, 1, '0, 0, "dsIn");
      for (int i = 0; i < 5; i++) cycle(15'h0200, 1, 0, '0, 0, "dsBusy");
      for (int i = 0; i < 3; i++) cycle(15'h0200, 1, 0, '0, 1, "dsHold");
      checkVal("dsHoldE", 64'(busIf.ctrl_out[W-1:0]), 64'h0042);
      checkVal("dsHoldDone", 64'(busIf.mc_done), 64'd1);
      for (int i = 0; i < 4; i++) cycle(15'h0200, 1, 0, '0, 0, "dsRel");
      checkVal("dsDoneCycles", 64'(nDone), 64'd4);

      // Flush E while busy with one count left: abort, no done
      nDone = 0;
      cycle(15'h0042, 1, 1, '0, 0, "flIn");
      for (int i = 0; i < 3; i++) cycle(15'h0300, 1, 0, '0, 0, "flBusy");
      cycle(15'h0300, 1, 0, 3'b001, 0, "flHit");
      checkVal("flStallDrop", 64'(busIf.mc_busy), 64'd0);
      checkVal("flEValid", 64'(busIf.valid_out[0]), 64'd0);
      for (int i = 0; i < 6; i++) cycle(15'h0300, 1, 0, '0, 0, "flAfter");
      checkVal("flNoDone", 64'(nDone), 64'd0);

      // stall_ext with flush of the last stage
      cycle(15'h0411, 1, 0, '0, 0, "sfFill");
      lowV0 = busIf.valid_out[1:0];
      low0  = busIf.ctrl_out[2*W-1:0];
      cycle(15'h0422, 1, 0, 3'b100, 1, "sfHit");
      checkVal("sfStage2", 64'(busIf.valid_out[2]), 64'd0);
      checkVal("sfLowCtrl", 64'(busIf.ctrl_out[2*W-1:0]), 64'(low0));
      checkVal("sfLowVld", 64'(busIf.valid_out[1:0]), 64'(lowV0));

      // Asynchronous reset in the middle of a busy window
      cycle(15'h0042, 1, 1, '0, 0, "rbIn");
      cycle(15'h0500, 1, 0, '0, 0, "rbD");
      cycle(15'h0500, 1, 0, '0, 0, "rbB");
      iCtrl = '0; iVld = 0; iMc = 0; iFlush = '0; iStall = 0;
      busIf.ctrl_in = '0; busIf.valid_in = 0; busIf.mc_in = 0;
      busIf.flush = '0; busIf.stall_ext = 0;
      #2 rst = 1'b0;
      #1;
      modelReset();
      checkAll("rbAsync");
      checkVal("rbStall", 64'(busIf.stall_up), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      cycle(15'h0000, 0, 0, '0, 0, "rbEmpty");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [STAGES-1:0] f;
         for (int k = 0; k < STAGES; k++) f[k] = ($urandom_range(0, 15) == 0);
         cycle(W'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               f, ($urandom_range(0, 7) == 0), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
